// File: rtl/hex_sr_pkg.sv
// Shared types and constants for the hex_sr host controller.
// Op codes, FSM states and the per-op pin drive helpers live here.
package hex_sr_pkg;

  localparam int HEX_W       = 6;
  localparam int CLK_DIV_MIN = 2;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_READ   = 2'b01,
    OP_VERIFY = 2'b10,
    OP_FLUSH  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI
  } state_e;

  // READ and VERIFY recirculate so the target contents survive the pass
  function automatic logic op_recirc(input op_e op);
    return (op == OP_READ) || (op == OP_VERIFY);
  endfunction

  function automatic logic [HEX_W-1:0] op_drive(input op_e op, input logic [HEX_W-1:0] pat);
    return (op == OP_LOAD) ? pat : '0;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for signals arriving from outside the clk domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hex_sr_host.sv
// Host-side driver for the hex_sr shift register: generates sr_clk, recirc
// and data, streams LENGTH words per command and captures/verifies readback.
module hex_sr_host
  import hex_sr_pkg::*;
#(
  parameter int LENGTH  = 70,
  parameter int CLK_DIV = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [HEX_W-1:0]            cmd_seed,
  input  logic [HEX_W-1:0]            cmd_step,
  output logic                        sr_clk,
  output logic                        sr_recirc,
  output logic [HEX_W-1:0]            sr_data_in,
  input  logic [HEX_W-1:0]            sr_data_out,
  output logic                        rd_valid,
  output logic [HEX_W-1:0]            rd_data,
  output logic [$clog2(LENGTH)-1:0]   rd_index,
  output logic                        done,
  output logic [$clog2(LENGTH+1)-1:0] err_count,
  output logic                        mismatch
);

  // The synchronizer needs at least two clk cycles per sr_clk half-period
  localparam int DIV    = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;
  localparam int PH_W   = $clog2(DIV);
  localparam int WORD_W = $clog2(LENGTH);
  localparam int ERR_W  = $clog2(LENGTH+1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DIV - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(LENGTH - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(LENGTH);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [HEX_W-1:0]   pat_q, pat_d;
  logic [HEX_W-1:0]   step_q, step_d;
  logic               sclk_q, sclk_d;
  logic               recirc_q, recirc_d;
  logic [HEX_W-1:0]   din_q, din_d;
  logic               rdv_q, rdv_d;
  logic [HEX_W-1:0]   rdata_q, rdata_d;
  logic [WORD_W-1:0]  ridx_q, ridx_d;
  logic               done_q, done_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               mism_q, mism_d;

  logic [HEX_W-1:0]   data_sync;
  logic [HEX_W-1:0]   pat_inc;
  op_e                cmd_op_e;

  sync2 #(.WIDTH(HEX_W)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sr_data_out),
    .q_o    (data_sync)
  );

  assign pat_inc  = pat_q + step_q;
  assign cmd_op_e = op_e'(cmd_op);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    phase_d  = phase_q;
    word_d   = word_q;
    pat_d    = pat_q;
    step_d   = step_q;
    sclk_d   = sclk_q;
    recirc_d = recirc_q;
    din_d    = din_q;
    rdv_d    = 1'b0;
    rdata_d  = rdata_q;
    ridx_d   = ridx_q;
    done_d   = 1'b0;
    err_d    = err_q;
    mism_d   = mism_q;

    // Compare runs in the cycle the captured word is presented
    if (rdv_q && (op_q == OP_VERIFY) && (rdata_q != pat_q)) begin
      mism_d = 1'b1;
      if (err_q != ERR_MAX) begin
        err_d = err_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        if (cmd_valid) begin
          state_d  = ST_SHIFT_LO;
          op_d     = cmd_op_e;
          step_d   = cmd_step;
          pat_d    = cmd_seed;
          phase_d  = '0;
          word_d   = '0;
          err_d    = '0;
          mism_d   = 1'b0;
          recirc_d = op_recirc(cmd_op_e);
          din_d    = op_drive(cmd_op_e, cmd_seed);
        end
      end
      ST_SHIFT_LO: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = ST_SHIFT_HI;
          sclk_d  = 1'b1;
          if (op_q != OP_LOAD) begin
            rdv_d   = 1'b1;
            rdata_d = data_sync;
            ridx_d  = word_q;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (word_q == WORD_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_SHIFT_LO;
            word_d   = word_q + 1'b1;
            pat_d    = pat_inc;
            recirc_d = op_recirc(op_q);
            din_d    = op_drive(op_q, pat_inc);
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      phase_q  <= '0;
      word_q   <= '0;
      pat_q    <= '0;
      step_q   <= '0;
      sclk_q   <= 1'b0;
      recirc_q <= 1'b0;
      din_q    <= '0;
      rdv_q    <= 1'b0;
      rdata_q  <= '0;
      ridx_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= '0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      phase_q  <= phase_d;
      word_q   <= word_d;
      pat_q    <= pat_d;
      step_q   <= step_d;
      sclk_q   <= sclk_d;
      recirc_q <= recirc_d;
      din_q    <= din_d;
      rdv_q    <= rdv_d;
      rdata_q  <= rdata_d;
      ridx_q   <= ridx_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mism_q   <= mism_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign sr_clk     = sclk_q;
  assign sr_recirc  = recirc_q;
  assign sr_data_in = din_q;
  assign rd_valid   = rdv_q;
  assign rd_data    = rdata_q;
  assign rd_index   = ridx_q;
  assign done       = done_q;
  assign err_count  = err_q;
  assign mismatch   = mism_q;

endmodule

// File: tb/tb_hex_sr_host.sv
// Scoreboard bench for hex_sr_host driving a behavioral 8-word hex_sr model.
module tb_hex_sr_host;
  import hex_sr_pkg::*;

  typedef logic [7:0][5:0] words_t;
  typedef struct { int idx; logic [5:0] data; } rd_exp_t;
  typedef struct { int latency; int err; logic mism; } done_exp_t;

  localparam words_t PAT_A     = {6'h1A, 6'h17, 6'h14, 6'h11, 6'h0E, 6'h0B, 6'h08, 6'h05};
  localparam words_t PAT_A_BAD = {6'h1A, 6'h17, 6'h14, 6'h11, 6'h3F, 6'h0B, 6'h08, 6'h05};
  localparam words_t PAT_B     = {6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 6'h00, 6'h3F, 6'h3E};
  localparam words_t PAT_C     = {6'h01, 6'h3A, 6'h33, 6'h2C, 6'h25, 6'h1E, 6'h17, 6'h10};
  localparam words_t PAT_ZERO  = '0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [5:0] cmd_seed = '0;
  logic [5:0] cmd_step = '0;
  logic       sr_clk;
  logic       sr_recirc;
  logic [5:0] sr_data_in;
  logic [5:0] sr_data_out;
  logic       rd_valid;
  logic [5:0] rd_data;
  logic [2:0] rd_index;
  logic       done;
  logic [3:0] err_count;
  logic       mismatch;

  int checks = 0;
  int failures = 0;
  int posCount = 0;
  int acceptPos = 0;
  int acceptCount = 0;
  int b2bCount = 0;
  int doneSeen = 0;
  int corruptReq = 0;
  int corruptAck = 0;

  rd_exp_t   rdQ[$];
  done_exp_t doneQ[$];

  logic [5:0] model [8];
  logic       srPrev;

  always #5 clk = ~clk;

  hex_sr_host #(.LENGTH(8), .CLK_DIV(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_seed    (cmd_seed),
    .cmd_step    (cmd_step),
    .sr_clk      (sr_clk),
    .sr_recirc   (sr_recirc),
    .sr_data_in  (sr_data_in),
    .sr_data_out (sr_data_out),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_index    (rd_index),
    .done        (done),
    .err_count   (err_count),
    .mismatch    (mismatch)
  );

  // Behavioral target: model[7] drives the pins, new word enters at model[0]
  always @(posedge clk) begin
    srPrev <= sr_clk;
    if (sr_clk && !srPrev) begin
      for (int i = 7; i > 0; i--) model[i] <= model[i-1];
      model[0] <= sr_recirc ? model[7] : sr_data_in;
    end else if (corruptReq != corruptAck) begin
      model[4] <= 6'h3F;
      corruptAck <= corruptReq;
    end
  end
  assign sr_data_out = model[7];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic expectRun(input bit hasReads, input words_t w, input int err, input bit mism);
    if (hasReads) begin
      for (int k = 0; k < 8; k++) rdQ.push_back('{idx: k, data: w[k]});
    end
    doneQ.push_back('{latency: 32, err: err, mism: mism});
  endtask

  task automatic applyStimulus(input op_e op, input logic [5:0] seed, input logic [5:0] step);
    int cyc;
    cyc = 0;
    @(negedge clk); #1;
    while (!cmd_ready && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (!cmd_ready) checkOutput("ready_timeout", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_seed  = seed;
    cmd_step  = step;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int target);
    int cyc;
    cyc = 0;
    while (doneSeen < target && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (doneSeen < target) checkOutput("done_timeout", doneSeen, target);
  endtask

  task automatic waitSrRises(input int n);
    int rises;
    int cyc;
    logic prev;
    rises = 0;
    cyc = 0;
    prev = sr_clk;
    while (rises < n && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
      if (sr_clk && !prev) rises++;
      prev = sr_clk;
    end
    if (rises < n) checkOutput("sr_rise_timeout", rises, n);
  endtask

  // Accept tracking at the active edge, using pre-edge values
  initial begin
    forever begin
      @(posedge clk);
      posCount++;
      if (rst_n && cmd_valid && cmd_ready) begin
        acceptPos = posCount;
        acceptCount++;
        if (done) b2bCount++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a word or done
  initial begin
    rd_exp_t   e;
    done_exp_t d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_valid) begin
          if (rdQ.size() == 0) begin
            checkOutput("rd_unexpected", int'(rd_valid), 0);
          end else begin
            e = rdQ.pop_front();
            checkOutput("rd_data", int'(rd_data), int'(e.data));
            checkOutput("rd_index", int'(rd_index), e.idx);
            checkOutput("rd_with_sr_clk", int'(sr_clk), 1);
          end
        end
        if (done) begin
          doneSeen++;
          if (doneQ.size() == 0) begin
            checkOutput("done_unexpected", int'(done), 0);
          end else begin
            d = doneQ.pop_front();
            checkOutput("done_latency", posCount - acceptPos, d.latency);
            checkOutput("done_err_count", int'(err_count), d.err);
            checkOutput("done_mismatch", int'(mismatch), int'(d.mism));
            checkOutput("done_cmd_ready", int'(cmd_ready), 1);
          end
        end
      end
    end
  end

  initial begin
    int highs;
    int acceptBase;
    int doneBase;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_sr_clk", int'(sr_clk), 0);
    checkOutput("rst_sr_recirc", int'(sr_recirc), 0);
    checkOutput("rst_sr_data_in", int'(sr_data_in), 0);
    checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("rst_rd_valid", int'(rd_valid), 0);
    checkOutput("rst_rd_data", int'(rd_data), 0);
    checkOutput("rst_rd_index", int'(rd_index), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err_count", int'(err_count), 0);
    checkOutput("rst_mismatch", int'(mismatch), 0);
    rst_n = 1'b1;

    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (sr_clk) highs++;
    end
    checkOutput("idle_sr_clk_highs", highs, 0);
    checkOutput("idle_cmd_ready", int'(cmd_ready), 1);

    $display("[TB] LOAD 05/03 then READ");
    expectRun(1'b0, PAT_ZERO, 0, 1'b0);
    applyStimulus(OP_LOAD, 6'h05, 6'h03);
    waitDone(1);
    expectRun(1'b1, PAT_A, 0, 1'b0);
    applyStimulus(OP_READ, 6'h00, 6'h00);
    waitDone(2);

    $display("[TB] VERIFY clean pattern");
    expectRun(1'b1, PAT_A, 0, 1'b0);
    applyStimulus(OP_VERIFY, 6'h05, 6'h03);
    waitDone(3);
    checkOutput("verify_clean_err", int'(err_count), 0);
    checkOutput("verify_clean_mism", int'(mismatch), 0);

    $display("[TB] VERIFY with word 3 corrupted");
    corruptReq++;
    repeat (3) @(negedge clk);
    expectRun(1'b1, PAT_A_BAD, 1, 1'b1);
    applyStimulus(OP_VERIFY, 6'h05, 6'h03);
    waitDone(4);
    checkOutput("verify_bad_err_held", int'(err_count), 1);
    checkOutput("verify_bad_mism_held", int'(mismatch), 1);
    expectRun(1'b1, PAT_A_BAD, 0, 1'b0);
    applyStimulus(OP_READ, 6'h00, 6'h00);
    checkOutput("accept_clears_err", int'(err_count), 0);
    checkOutput("accept_clears_mism", int'(mismatch), 0);
    waitDone(5);

    $display("[TB] wrap LOAD, FLUSH, READ zeros");
    expectRun(1'b0, PAT_ZERO, 0, 1'b0);
    applyStimulus(OP_LOAD, 6'h3E, 6'h01);
    waitDone(6);
    expectRun(1'b1, PAT_B, 0, 1'b0);
    applyStimulus(OP_FLUSH, 6'h00, 6'h00);
    waitDone(7);
    expectRun(1'b1, PAT_ZERO, 0, 1'b0);
    applyStimulus(OP_READ, 6'h00, 6'h00);
    waitDone(8);

    $display("[TB] busy cmd_valid ignored, back-to-back accept");
    acceptBase = acceptCount;
    expectRun(1'b0, PAT_ZERO, 0, 1'b0);
    expectRun(1'b1, PAT_C, 0, 1'b0);
    @(negedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_seed  = 6'h10;
    cmd_step  = 6'h07;
    @(posedge clk); #1;
    cmd_op    = OP_READ;
    cmd_seed  = 6'h00;
    cmd_step  = 6'h00;
    waitDone(9);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    waitDone(10);
    checkOutput("b2b_accept_count", acceptCount - acceptBase, 2);
    checkOutput("b2b_in_done_cycle", b2bCount, 1);

    $display("[TB] reset during pulse 4 of LOAD");
    applyStimulus(OP_LOAD, 6'h2A, 6'h05);
    waitSrRises(4);
    checkOutput("pre_reset_sr_clk", int'(sr_clk), 1);
    doneBase = doneSeen;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_sr_clk", int'(sr_clk), 0);
    checkOutput("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_cmd_ready", int'(cmd_ready), 1);
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (sr_clk) highs++;
    end
    checkOutput("midrst_no_done", doneSeen, doneBase);
    checkOutput("midrst_sr_clk_idle", highs, 0);

    checkOutput("rd_queue_drained", rdQ.size(), 0);
    checkOutput("done_queue_drained", doneQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
